// File: rtl/demux_1_4_stream_pkg.sv
// rtl/demux_1_4_stream_pkg.sv - shared types and constants for demux_1_4_stream
package demux_1_4_stream_pkg;

  localparam int NUM_OUT = 4;

  typedef logic [1:0] dest_t;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register slice for one demux destination
module demux_slot
  import demux_1_4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out
);

  slot_state_t state;

  // Load wins over drain, so a drain and load in the same cycle keeps the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      data_out <= '0;
    end else if (load) begin
      state    <= SLOT_FULL;
      data_out <= data_in;
    end else if (state == SLOT_FULL && ready) begin
      state    <= SLOT_EMPTY;
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1_4_stream.sv
// rtl/demux_1_4_stream.sv - registered 1:4 stream demux; DEMUX_1_4_STREAM_RR_EN selects round-robin steering
module demux_1_4_stream
  import demux_1_4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  dest_t            dest;
  logic             accept;
  logic [WIDTH-1:0] slot_data [NUM_OUT];

`ifdef DEMUX_1_4_STREAM_RR_EN
  dest_t rr_ptr;
  logic  unused_sel;

  assign unused_sel = ^in_sel;
  assign dest       = rr_ptr;

  // Pointer only moves on an accepted beat; a stalled slot blocks the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  assign dest = in_sel;
`endif

  assign in_ready = !out_valid[dest] || out_ready[dest];
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && (dest == dest_t'(k))),
      .data_in  (in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data_out (slot_data[k])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb/tb_demux_1_4_stream.sv - directed self-checking bench for demux_1_4_stream
module tb_demux_1_4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1_4_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] sel, input logic [7:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    check("reset_out_valid", out_valid, 4'b0000);
    check("reset_in_ready",  in_ready,  1'b1);
    check("reset_data",      {out_data0, out_data1, out_data2, out_data3}, 32'h0);

`ifndef DEMUX_1_4_STREAM_RR_EN
    // single beat to slot 2, then a blocked second beat
    beat(2'd2, 8'hA5);
    check("t1_in_ready", in_ready, 1'b1);
    step();
    beat(2'd2, 8'hB6);
    check("t1_out_valid", out_valid, 4'b0100);
    check("t1_data2",     out_data2, 8'hA5);
    check("t1_blocked",   in_ready,  1'b0);
    step();
    check("t1_hold_data2", out_data2, 8'hA5);
    out_ready = 4'b0100;
    #1;
    check("t1_unblocked", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("t1_second_valid", out_valid, 4'b0100);
    check("t1_second_data",  out_data2, 8'hB6);
    step();
    check("t1_drained", out_valid, 4'b0000);

    // drain and load slot 1 in the same cycle
    out_ready = 4'b0000;
    beat(2'd1, 8'h77);
    step();
    check("t2_first", out_data1, 8'h77);
    out_ready = 4'b0010;
    beat(2'd1, 8'h3C);
    check("t2_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("t2_out_valid", out_valid, 4'b0010);
    check("t2_data1",     out_data1, 8'h3C);
    step();
    check("t2_drained", out_valid, 4'b0000);

    // sustained one beat per cycle into slot 0
    out_ready = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      beat(2'd0, 8'h20 + 8'(i));
      check("tp_in_ready", in_ready, 1'b1);
      step();
      check("tp_data0",  out_data0, 8'h20 + 8'(i));
      check("tp_valid0", out_valid, 4'b0001);
    end
    in_valid = 1'b0;
    step();
    check("tp_drained", out_valid, 4'b0000);

    // back-to-back beats to all four slots with every consumer stalled
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      beat(2'(i), 8'h10 + 8'(i));
      check("t3_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    check("t3_out_valid", out_valid, 4'b1111);
    check("t3_data", {out_data3, out_data2, out_data1, out_data0}, 32'h13121110);

    // slot 3 stalled and full, beat to slot 0 still passes
    out_ready = 4'b0001;
    step();
    out_ready = 4'b0000;
    check("t4_pre_valid", out_valid, 4'b1110);
    beat(2'd3, 8'hEE);
    check("t4_sel3_blocked", in_ready, 1'b0);
    beat(2'd0, 8'h55);
    check("t4_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("t4_out_valid", out_valid, 4'b1111);
    check("t4_data0",     out_data0, 8'h55);
    check("t4_data3",     out_data3, 8'h13);

    // reset wins over an accepting beat
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    check("t5_pre_valid", out_valid, 4'b1011);
    beat(2'd2, 8'h99);
    check("t5_accepting", in_ready, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 4'b0000);
    check("t5_data", {out_data0, out_data1, out_data2, out_data3}, 32'h0);
    check("t5_in_ready", in_ready, 1'b1);
`else
    // round-robin: destinations 0,1,2,3,0 regardless of in_sel
    out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      beat(2'd3, 8'h40 + 8'(i));
      check("rr_in_ready", in_ready, 1'b1);
      step();
      check("rr_out_valid", out_valid, 4'b0001 << (i % 4));
      case (i % 4)
        0: check("rr_data0", out_data0, 8'h40 + 8'(i));
        1: check("rr_data1", out_data1, 8'h40 + 8'(i));
        2: check("rr_data2", out_data2, 8'h40 + 8'(i));
        default: check("rr_data3", out_data3, 8'h40 + 8'(i));
      endcase
    end
    in_valid = 1'b0;

    // stalled slot 1 blocks the input once the pointer returns to it
    do_reset();
    out_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      beat(2'd0, 8'h60 + 8'(i));
      check("rr_stall_fill", in_ready, 1'b1);
      step();
    end
    beat(2'd0, 8'h65);
    check("rr_stall_blocked", in_ready, 1'b0);
    check("rr_stall_data1",   out_data1, 8'h61);
    step();
    check("rr_stall_still", in_ready, 1'b0);
    out_ready = 4'b1111;
    #1;
    check("rr_stall_release", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("rr_stall_valid", out_valid, 4'b0010);
    check("rr_stall_new",   out_data1, 8'h65);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Registered 1:4 stream demultiplexer, the inverse of the team's parametrizable 4:1 MUX. It accepts one WIDTH-bit stream with valid/ready handshaking. Each beat is steered to one of four output streams, each with its own one-entry output register. It sits where one producer (ALU result bus, load path) fans out to four consumers that may stall independently.

## Interface
- WIDTH, 8, data width of the input and of each output stream.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  producer has a beat on in_data.
- in_ready  output  1  block can accept the beat this cycle.
- in_data  input  WIDTH  beat payload.
- in_sel  input  2  destination index 0..3, sampled with the beat.
- out_valid  output  4  bit k: output slot k holds a beat.
- out_ready  input  4  bit k: consumer k takes the beat this cycle.
- out_data0..out_data3  output  WIDTH each  payload of slot k.

## Operation
- Destination selection:
  - Default build: destination d = in_sel.
  - RR build: destination d = rr_ptr (see Configuration).
- Each slot k has a two-state FSM with a data register.
  - EMPTY: out_valid[k]=0.
  - FULL: out_valid[k]=1, out_data_k holds the stored beat.
- in_ready = !out_valid[d] || out_ready[d]. This is combinational and depends on current-cycle in_sel (or rr_ptr) and out_ready.
- Accept = in_valid && in_ready. On accept, slot d loads in_data and is FULL next cycle.
- Slot k drains when out_valid[k] && out_ready[k].
- Slot transitions:
  - Drain with no load: FULL→EMPTY.
  - Load only: EMPTY→FULL.
  - Drain and load in the same cycle: stays FULL with the new data. This gives 1 beat/cycle sustained per slot.
- Slots other than d are unaffected by the input. Multiple slots may drain in the same cycle.
- out_data_k is stable while out_valid[k]=1 and out_ready[k]=0. Its contents are don't-care when EMPTY; the implementation holds the last value.
- in_data and in_sel must stay stable while in_valid=1 && in_ready=0. in_valid must not drop before accept; violations are undefined.
- The block never drops, duplicates or reorders beats within one destination.

## Timing
- Latency: accept in cycle N → out_valid[d]=1 with data in cycle N+1.
- Throughput: 1 beat/cycle into any slot whose consumer holds out_ready high.
- Reset (rst=1 at an edge):
  - out_valid=4'b0000, all slots EMPTY, data registers cleared to 0, rr_ptr=0.
  - in_ready evaluates to 1 after reset.
- Reset has priority over any simultaneous load or drain. Beats in flight are discarded.
- in_ready to in_valid has no combinational path. in_ready depends only on out_ready, out_valid and in_sel.

## Configuration
- Macro: DEMUX_1_4_STREAM_RR_EN.
- Defined:
  - in_sel is ignored.
  - A 2-bit rr_ptr selects the destination and advances by 1 (mod 4, 3→0) on every accept only.
  - A stall on slot rr_ptr blocks the input; there is no skipping.
- Not defined:
  - rr_ptr is absent and destination = in_sel.
- The port list is identical in both builds.

## Structure
- Shared package demux_1_4_stream_pkg holds:
  - NUM_OUT = 4.
  - typedef logic [1:0] dest_t.
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t.
- Sub-module demux_slot (WIDTH parameter): one-entry register slice with load, data_in, ready, valid and data_out, instantiated four times.
- The top level contains destination decode, in_ready mux and rr_ptr.

## Test plan
- Reset then in_valid=1, in_sel=2, in_data=8'hA5, out_ready=4'b0000:
  - accepted, next cycle out_valid=4'b0100, out_data2=8'hA5.
  - a second beat to sel 2 sees in_ready=0.
- Slot 1 FULL and out_ready[1]=1, new beat 8'h3C to sel 1 in the same cycle:
  - accepted, out_valid[1] stays 1, out_data1=8'h3C next cycle.
- Back-to-back beats 0x10,0x11,0x12,0x13 to sel 0,1,2,3 with all out_ready=0:
  - all accepted over 4 cycles, out_valid=4'b1111 with matching data.
- Slot 3 stalled and full, beat to sel 0: in_ready=1, beat lands in slot 0, slot 3 data unchanged.
- rst asserted while out_valid=4'b1011 and a beat is accepting: next cycle out_valid=0 and out_data0..3=0.
- RR build, 5 beats with all out_ready=1:
  - destinations 0,1,2,3,0 regardless of in_sel.
  - holding out_ready[1]=0 stalls the second beat until it is released.
